decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second pipeline stage, directly downstream of the fetch stage.
- Latches fetched and pre-decoded instruction fields plus branch-prediction metadata into the D pipeline register.
- Owns the 32x32 architectural register file and produces forwarded rs1/rs2 operand values.
- Detects load-use hazards and drops wrong-path instructions on an execute redirect.

Parameters:
- N, 12, predictor history width; passed to the packed spec-bus width.
- RAS_DEPTH, 16, RAS entries; passed to the packed spec-bus width.
- RAS_W, 4, RAS stack-pointer width.
- SPEC_W, 4+2*N+32+RAS_W+RAS_DEPTH*32, width of the packed prediction metadata bus.
  - Packing order, MSB to LSB: is_jump, pred_taken, ghr, pred_pc, ras_sp, ras_snap, lht, gshare_taken, local_taken.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- f_to_d_valid  in  1  fetch has a valid instruction
- d_allow_in  out  1  decode can accept this cycle
- e_allow_in  in  1  execute can accept this cycle
- d_to_e_valid  out  1  decode output is valid and ready
- flush  in  1  execute redirect (mispredict); kills the decode contents
- f_pc  in  32  fetch PC
- f_opcode  in  7  opcode
- f_rd  in  5  destination register
- f_rs1  in  5  source register 1
- f_rs2  in  5  source register 2
- f_funct  in  10  funct field
- f_imm  in  32  immediate
- f_instr_type  in  3  instruction type (TYPER/I/S/B/U/J)
- f_spec_bus  in  SPEC_W  packed prediction metadata
- e_valid  in  1  execute stage holds a valid instruction
- e_wr_en  in  1  execute instruction writes rd
- e_is_load  in  1  execute instruction is a load
- e_rd  in  5  execute destination register
- e_result  in  32  execute ALU result
- m_wr_en  in  1  memory-stage write enable
- m_rd  in  5  memory-stage destination register
- m_result  in  32  memory-stage result
- w_wr_en  in  1  writeback write enable
- w_rd  in  5  writeback destination register
- w_data  in  32  writeback data
- d_pc  out  32  latched PC
- d_opcode  out  7  latched opcode
- d_rd  out  5  latched rd
- d_rs1  out  5  latched rs1
- d_rs2  out  5  latched rs2
- d_funct  out  10  latched funct
- d_imm  out  32  latched immediate
- d_instr_type  out  3  latched instruction type
- d_spec_bus  out  SPEC_W  latched prediction metadata
- d_rs1_val  out  32  forwarded rs1 operand
- d_rs2_val  out  32  forwarded rs2 operand

Behaviour:
- Reset (sync, rst=1 at posedge):
  - d_valid=0; all latched outputs = 0.
  - All 32 registers = 0.
  - Consequently d_to_e_valid=0 and d_allow_in=1.
- Handshake:
  - d_ready_go = ~stall.
  - d_allow_in = ~d_valid | (d_ready_go & e_allow_in).
  - d_to_e_valid = d_valid & d_ready_go.
- Capture:
  - When d_allow_in & f_to_d_valid at posedge, latch all f_* fields and f_spec_bus; d_valid<=1.
  - When d_allow_in & ~f_to_d_valid, d_valid<=0.
  - Otherwise hold all state.
  - Latency: one cycle from fetch to decode.
- Flush:
  - flush=1 at posedge forces d_valid<=0, with priority over capture, even if f_to_d_valid & d_allow_in in the same cycle.
  - Latched fields may update; they are don't-care while invalid.
- Source use:
  - use_rs1 for types R, I, S, B.
  - use_rs2 for types R, S, B.
  - U and J types use no sources.
- Load-use stall:
  - stall = d_valid & e_valid & e_is_load & e_wr_en & e_rd!=0 & ((use_rs1 & e_rd==d_rs1) | (use_rs2 & e_rd==d_rs2)).
  - The stall holds the D register and d_valid.
- Operand read (combinational), per source, in priority order:
  1. rs==0 gives 0.
  2. E match (e_valid & e_wr_en & ~e_is_load) gives e_result.
  3. M match (m_wr_en) gives m_result.
  4. W match (w_wr_en) gives w_data.
  5. Otherwise the regfile value.
- Regfile write:
  - At posedge when w_wr_en & w_rd!=0 & ~rst.
  - x0 is never written; reads of x0 always return 0.
- Simultaneous events:
  - flush together with stall: flush wins; d_valid<=0.
  - A W write and a read of the same register in the same cycle return w_data.

Optional Feature:
- Macro: DECODE_FWD_EN.
- Defined:
  - E and M bypasses active as specified under Behaviour.
  - Only the load-use stall applies.
- Undefined:
  - E and M bypass paths are removed.
  - stall additionally asserts while E (e_valid & e_wr_en) or M (m_wr_en) has rd!=0 matching a used source.
  - The W write-through bypass remains.

Decomposition:
- Opcode and type constants (OP_*, TYPER/I/S/B/U/J) come from the shared define.v.
- SPEC_W field offsets go in a shared localparam include so fetch, decode and execute pack and unpack the bus identically.
- One natural sub-module: regfile_2r1w (32x32, two async reads, one sync write, x0 hardwired to 0, internal write-through).

Test Plan:
- Reset, then feed f_pc=0x80000000, addi x1,x0,5 with f_to_d_valid=1 and e_allow_in=1 -> next cycle d_to_e_valid=1, d_pc=0x80000000, d_imm=5, d_rs1_val=0.
- Load x5 in E (e_is_load=1, e_rd=5), decode holds add x6,x5,x5 -> d_allow_in=0 and d_to_e_valid=0; the cycle after E clears, d_to_e_valid=1.
- E writes x3=0x11, M writes x3=0x22, W writes x3=0x33 simultaneously -> d_rs1_val=0x11; with DECODE_FWD_EN undefined -> stall instead.
- flush=1 in the same cycle as f_to_d_valid=1 and d_allow_in=1 -> next cycle d_valid=0 and d_to_e_valid=0.
- w_wr_en=1, w_rd=0, w_data=0xFFFFFFFF, then read x0 -> d_rs1_val=0; w_wr_en=1 to x7 with the same-cycle read of x7 -> d_rs1_val=w_data.
- e_allow_in=0 for 3 cycles with valid input -> D register holds, d_allow_in=0, no capture; the captured instruction issues once when e_allow_in returns to 1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode-stage types: instruction-type and opcode constants, the D-register field
// bundle, and bit offsets of the packed prediction-metadata bus used by fetch/decode/execute.
package decode_stage_pkg;

    localparam logic [2:0] TYPER = 3'd0;
    localparam logic [2:0] TYPEI = 3'd1;
    localparam logic [2:0] TYPES = 3'd2;
    localparam logic [2:0] TYPEB = 3'd3;
    localparam logic [2:0] TYPEU = 3'd4;
    localparam logic [2:0] TYPEJ = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [9:0]  funct;
        logic [31:0] imm;
        logic [2:0]  instr_type;
    } d_fields_t;

    // Spec bus, LSB upward: local_taken, gshare_taken, lht, ras_snap, ras_sp, pred_pc, ghr,
    // pred_taken, is_jump.
    localparam int SPEC_LOCAL_TAKEN  = 0;
    localparam int SPEC_GSHARE_TAKEN = 1;
    localparam int SPEC_LHT_LSB      = 2;

    function automatic int spec_ras_snap_lsb(input int n);
        return 2 + n;
    endfunction

    function automatic int spec_ras_sp_lsb(input int n, input int ras_depth);
        return 2 + n + ras_depth * 32;
    endfunction

    function automatic int spec_pred_pc_lsb(input int n, input int ras_w, input int ras_depth);
        return 2 + n + ras_depth * 32 + ras_w;
    endfunction

    function automatic int spec_ghr_lsb(input int n, input int ras_w, input int ras_depth);
        return spec_pred_pc_lsb(n, ras_w, ras_depth) + 32;
    endfunction

    function automatic int spec_width(input int n, input int ras_w, input int ras_depth);
        return 4 + 2 * n + 32 + ras_w + ras_depth * 32;
    endfunction

    function automatic logic uses_rs1(input logic [2:0] t);
        return (t == TYPER) || (t == TYPEI) || (t == TYPES) || (t == TYPEB);
    endfunction

    function automatic logic uses_rs2(input logic [2:0] t);
        return (t == TYPER) || (t == TYPES) || (t == TYPEB);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch->decode->execute pipeline bus: handshake, fetched fields in, latched fields out.
interface decode_stage_if #(parameter int SPEC_W = 576);
    logic              f_to_d_valid;
    logic              d_allow_in;
    logic              e_allow_in;
    logic              d_to_e_valid;
    logic              flush;
    logic [31:0]       f_pc;
    logic [6:0]        f_opcode;
    logic [4:0]        f_rd;
    logic [4:0]        f_rs1;
    logic [4:0]        f_rs2;
    logic [9:0]        f_funct;
    logic [31:0]       f_imm;
    logic [2:0]        f_instr_type;
    logic [SPEC_W-1:0] f_spec_bus;
    logic [31:0]       d_pc;
    logic [6:0]        d_opcode;
    logic [4:0]        d_rd;
    logic [4:0]        d_rs1;
    logic [4:0]        d_rs2;
    logic [9:0]        d_funct;
    logic [31:0]       d_imm;
    logic [2:0]        d_instr_type;
    logic [SPEC_W-1:0] d_spec_bus;
    logic [31:0]       d_rs1_val;
    logic [31:0]       d_rs2_val;

    modport master (
        output f_to_d_valid, e_allow_in, flush, f_pc, f_opcode, f_rd, f_rs1, f_rs2,
               f_funct, f_imm, f_instr_type, f_spec_bus,
        input  d_allow_in, d_to_e_valid, d_pc, d_opcode, d_rd, d_rs1, d_rs2, d_funct,
               d_imm, d_instr_type, d_spec_bus, d_rs1_val, d_rs2_val
    );

    modport slave (
        input  f_to_d_valid, e_allow_in, flush, f_pc, f_opcode, f_rd, f_rs1, f_rs2,
               f_funct, f_imm, f_instr_type, f_spec_bus,
        output d_allow_in, d_to_e_valid, d_pc, d_opcode, d_rd, d_rs1, d_rs2, d_funct,
               d_imm, d_instr_type, d_spec_bus, d_rs1_val, d_rs2_val
    );
endinterface

// File: rtl/decode_stage_regfile.sv
// 32x32 architectural register file: two async reads, one sync write, x0 hardwired to zero,
// and write-through so a same-cycle read of the register being written sees the new data.
module decode_stage_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0][31:0] regs;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == 5'd0)
            rdata1 = '0;
        else if (we && waddr == raddr1)
            rdata1 = wdata;
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == 5'd0)
            rdata2 = '0;
        else if (we && waddr == raddr2)
            rdata2 = wdata;
    end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: D pipeline register, register file, operand bypass and hazard stall.
// Build option DECODE_FWD_EN enables the E/M bypasses; without it, E/M dependencies stall.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int N         = 12,
    parameter int RAS_DEPTH = 16,
    parameter int RAS_W     = 4,
    parameter int SPEC_W    = spec_width(N, RAS_W, RAS_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus,
    input  logic          e_valid,
    input  logic          e_wr_en,
    input  logic          e_is_load,
    input  logic [4:0]    e_rd,
    input  logic [31:0]   e_result,
    input  logic          m_wr_en,
    input  logic [4:0]    m_rd,
    input  logic [31:0]   m_result,
    input  logic          w_wr_en,
    input  logic [4:0]    w_rd,
    input  logic [31:0]   w_data
);
    d_fields_t         d_q;
    logic [SPEC_W-1:0] spec_q;
    logic              d_valid;
    logic              use1, use2, e_hit, stall, ready_go, allow_in;
    logic [31:0]       rf_rs1, rf_rs2, rs1_val, rs2_val;

    assign use1  = uses_rs1(d_q.instr_type);
    assign use2  = uses_rs2(d_q.instr_type);
    assign e_hit = e_valid && e_wr_en && e_rd != 5'd0 &&
                   ((use1 && e_rd == d_q.rs1) || (use2 && e_rd == d_q.rs2));

`ifdef DECODE_FWD_EN
    assign stall = d_valid && e_hit && e_is_load;
`else
    logic m_hit;
    assign m_hit = m_wr_en && m_rd != 5'd0 &&
                   ((use1 && m_rd == d_q.rs1) || (use2 && m_rd == d_q.rs2));
    // Without E/M bypasses any in-flight producer of a used source must drain first.
    assign stall = d_valid && (e_hit || m_hit);
    logic unused_fwd;
    assign unused_fwd = ^{e_is_load, e_result, m_result};
`endif

    assign ready_go         = ~stall;
    assign allow_in         = ~d_valid || (ready_go && bus.e_allow_in);
    assign bus.d_allow_in   = allow_in;
    assign bus.d_to_e_valid = d_valid && ready_go;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_valid <= 1'b0;
            d_q     <= '0;
            spec_q  <= '0;
        end else begin
            if (allow_in && bus.f_to_d_valid) begin
                d_q <= '{pc: bus.f_pc, opcode: bus.f_opcode, rd: bus.f_rd, rs1: bus.f_rs1,
                         rs2: bus.f_rs2, funct: bus.f_funct, imm: bus.f_imm,
                         instr_type: bus.f_instr_type};
                spec_q <= bus.f_spec_bus;
            end
            if (bus.flush)
                d_valid <= 1'b0;
            else if (allow_in)
                d_valid <= bus.f_to_d_valid;
        end
    end

    decode_stage_regfile u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (w_wr_en),
        .waddr  (w_rd),
        .wdata  (w_data),
        .raddr1 (d_q.rs1),
        .raddr2 (d_q.rs2),
        .rdata1 (rf_rs1),
        .rdata2 (rf_rs2)
    );

    // Youngest producer wins; the regfile already folds in the W write-through.
    always_comb begin
        rs1_val = rf_rs1;
        if (d_q.rs1 == 5'd0)
            rs1_val = '0;
`ifdef DECODE_FWD_EN
        else if (e_valid && e_wr_en && !e_is_load && e_rd == d_q.rs1)
            rs1_val = e_result;
        else if (m_wr_en && m_rd == d_q.rs1)
            rs1_val = m_result;
`endif
    end

    always_comb begin
        rs2_val = rf_rs2;
        if (d_q.rs2 == 5'd0)
            rs2_val = '0;
`ifdef DECODE_FWD_EN
        else if (e_valid && e_wr_en && !e_is_load && e_rd == d_q.rs2)
            rs2_val = e_result;
        else if (m_wr_en && m_rd == d_q.rs2)
            rs2_val = m_result;
`endif
    end

    assign bus.d_pc         = d_q.pc;
    assign bus.d_opcode     = d_q.opcode;
    assign bus.d_rd         = d_q.rd;
    assign bus.d_rs1        = d_q.rs1;
    assign bus.d_rs2        = d_q.rs2;
    assign bus.d_funct      = d_q.funct;
    assign bus.d_imm        = d_q.imm;
    assign bus.d_instr_type = d_q.instr_type;
    assign bus.d_spec_bus   = spec_q;
    assign bus.d_rs1_val    = rs1_val;
    assign bus.d_rs2_val    = rs2_val;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed stimulus pushes expected issues into a queue,
// an independent monitor pops and compares on every decode->execute transfer.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int N         = 12;
    localparam int RAS_DEPTH = 16;
    localparam int RAS_W     = 4;
    localparam int SPEC_W    = 4 + 2 * N + 32 + RAS_W + RAS_DEPTH * 32;

    typedef struct {
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [31:0]       rs1v;
        logic [31:0]       rs2v;
        logic [SPEC_W-1:0] spec;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic e_valid, e_wr_en, e_is_load, m_wr_en, w_wr_en;
    logic [4:0] e_rd, m_rd, w_rd;
    logic [31:0] e_result, m_result, w_data;
    int checks = 0;
    int errors = 0;
    exp_t sbq[$];

    decode_stage_if #(.SPEC_W(SPEC_W)) bus ();

    decode_stage #(.N(N), .RAS_DEPTH(RAS_DEPTH), .RAS_W(RAS_W), .SPEC_W(SPEC_W)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .e_valid(e_valid), .e_wr_en(e_wr_en), .e_is_load(e_is_load), .e_rd(e_rd),
        .e_result(e_result), .m_wr_en(m_wr_en), .m_rd(m_rd), .m_result(m_result),
        .w_wr_en(w_wr_en), .w_rd(w_rd), .w_data(w_data)
    );

    always #5 clk = ~clk;

    function automatic logic [SPEC_W-1:0] make_spec(input int seed);
        logic [SPEC_W-1:0] s;
        s = '0;
        for (int k = 0; k < SPEC_W / 32; k++)
            s[k*32 +: 32] = (32'(seed) * 32'h9E3779B9) ^ 32'(k);
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.d_to_e_valid === 1'b1 && bus.e_allow_in === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue pc got %h expected none", bus.d_pc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_pc", bus.d_pc, e.pc);
                chk("sb_imm", bus.d_imm, e.imm);
                chk("sb_rs1_val", bus.d_rs1_val, e.rs1v);
                chk("sb_rs2_val", bus.d_rs2_val, e.rs2v);
                checks++;
                if (bus.d_spec_bus !== e.spec) begin
                    errors++;
                    $display("FAIL sb_spec_bus pc %h got %h expected %h", e.pc, bus.d_spec_bus, e.spec);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, imm, rs1v, rs2v, input int seed);
        exp_t e;
        e.pc = pc; e.imm = imm; e.rs1v = rs1v; e.rs2v = rs2v; e.spec = make_spec(seed);
        sbq.push_back(e);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                         input logic [31:0] imm, input logic [2:0] t, input int seed);
        bus.f_pc = pc; bus.f_opcode = op; bus.f_rd = rd; bus.f_rs1 = rs1; bus.f_rs2 = rs2;
        bus.f_funct = 10'd0; bus.f_imm = imm; bus.f_instr_type = t; bus.f_spec_bus = make_spec(seed);
        bus.f_to_d_valid = 1'b1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                         input logic [31:0] imm, input logic [2:0] t, input int seed);
        drive(pc, op, rd, rs1, rs2, imm, t, seed);
        step();
        bus.f_to_d_valid = 1'b0;
    endtask

    task automatic clear_bypass();
        e_valid = 0; e_wr_en = 0; e_is_load = 0; e_rd = 0; e_result = 0;
        m_wr_en = 0; m_rd = 0; m_result = 0; w_wr_en = 0; w_rd = 0; w_data = 0;
    endtask

    // x3 dependency with W always writing 0x33 and optional E (0x11) / M (0x22) producers.
    task automatic fwd_case(input logic e_on, m_on, input logic [31:0] fwd_exp,
                            input logic [31:0] pc, input int seed);
        e_valid = e_on; e_wr_en = 1; e_is_load = 0; e_rd = 3; e_result = 32'h11;
        m_wr_en = m_on; m_rd = 3; m_result = 32'h22;
        w_wr_en = 1; w_rd = 3; w_data = 32'h33;
`ifdef DECODE_FWD_EN
        push(pc, 0, fwd_exp, 0, seed);
        issue(pc, OP_REG, 4, 3, 0, 0, TYPER, seed);
        @(negedge clk);
        chk("fwd_issue_valid", 32'(bus.d_to_e_valid), 1);
`else
        push(pc, 0, 32'h33, 0, seed);
        issue(pc, OP_REG, 4, 3, 0, 0, TYPER, seed);
        @(negedge clk);
        if (e_on || m_on) begin
            chk("nofwd_stall_valid", 32'(bus.d_to_e_valid), 0);
            chk("nofwd_stall_allow", 32'(bus.d_allow_in), 0);
            step();
            clear_bypass();
            @(negedge clk);
            chk("nofwd_release_valid", 32'(bus.d_to_e_valid), 1);
        end else begin
            chk("nofwd_w_only_valid", 32'(bus.d_to_e_valid), 1);
        end
        if (fwd_exp == 32'h0) $display("note: unused forward value");
`endif
        step();
        clear_bypass();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clear_bypass();
        bus.f_to_d_valid = 0; bus.e_allow_in = 1; bus.flush = 0;
        bus.f_pc = 0; bus.f_opcode = 0; bus.f_rd = 0; bus.f_rs1 = 0; bus.f_rs2 = 0;
        bus.f_funct = 0; bus.f_imm = 0; bus.f_instr_type = 0; bus.f_spec_bus = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_to_e_valid", 32'(bus.d_to_e_valid), 0);
        chk("reset_allow_in", 32'(bus.d_allow_in), 1);
        chk("reset_d_pc", bus.d_pc, 0);
        step();
        rst = 0;

        // addi x1,x0,5: one-cycle latency into D
        push(32'h8000_0000, 5, 0, 0, 1);
        issue(32'h8000_0000, OP_IMM, 1, 0, 5, 5, TYPEI, 1);
        @(negedge clk);
        chk("first_issue_latency", 32'(bus.d_to_e_valid), 1);
        step();

        // x5 = 0x1234, then load-use on x5
        w_wr_en = 1; w_rd = 5; w_data = 32'h1234;
        step();
        clear_bypass();
        e_valid = 1; e_wr_en = 1; e_is_load = 1; e_rd = 5; e_result = 32'hBAD;
        push(32'h8000_0004, 0, 32'h1234, 32'h1234, 2);
        issue(32'h8000_0004, OP_REG, 6, 5, 5, 0, TYPER, 2);
        @(negedge clk);
        chk("load_use_allow", 32'(bus.d_allow_in), 0);
        chk("load_use_valid", 32'(bus.d_to_e_valid), 0);
        step();
        @(negedge clk);
        chk("load_use_hold_valid", 32'(bus.d_to_e_valid), 0);
        chk("load_use_hold_pc", bus.d_pc, 32'h8000_0004);
        step();
        clear_bypass();
        @(negedge clk);
        chk("load_use_release", 32'(bus.d_to_e_valid), 1);
        step();

        // bypass priority on x3
        fwd_case(1, 1, 32'h11, 32'h100, 3);
        fwd_case(0, 1, 32'h22, 32'h104, 4);
        fwd_case(0, 0, 32'h33, 32'h108, 10);

        // flush beats capture
        drive(32'h200, OP_IMM, 1, 0, 0, 7, TYPEI, 11);
        bus.flush = 1;
        step();
        bus.f_to_d_valid = 0; bus.flush = 0;
        @(negedge clk);
        chk("flush_capture_valid", 32'(bus.d_to_e_valid), 0);
        chk("flush_capture_allow", 32'(bus.d_allow_in), 1);
        step();

        // flush beats stall
        e_valid = 1; e_wr_en = 1; e_is_load = 1; e_rd = 5;
        issue(32'h204, OP_REG, 6, 5, 5, 0, TYPER, 12);
        @(negedge clk);
        chk("flush_stall_pre", 32'(bus.d_to_e_valid), 0);
        step();
        bus.flush = 1;
        step();
        bus.flush = 0;
        clear_bypass();
        @(negedge clk);
        chk("flush_stall_valid", 32'(bus.d_to_e_valid), 0);
        chk("flush_stall_allow", 32'(bus.d_allow_in), 1);
        step();

        // x0 write ignored; W write-through on x7; stored value read back
        w_wr_en = 1; w_rd = 0; w_data = 32'hFFFF_FFFF;
        step();
        clear_bypass();
        push(32'h300, 1, 0, 0, 5);
        issue(32'h300, OP_IMM, 8, 0, 0, 1, TYPEI, 5);
        @(negedge clk);
        chk("x0_issue_valid", 32'(bus.d_to_e_valid), 1);
        step();
        push(32'h304, 0, 32'hDEAD_BEEF, 0, 6);
        issue(32'h304, OP_REG, 9, 7, 0, 0, TYPER, 6);
        w_wr_en = 1; w_rd = 7; w_data = 32'hDEAD_BEEF;
        @(negedge clk);
        step();
        clear_bypass();
        push(32'h308, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 7);
        issue(32'h308, OP_REG, 9, 7, 7, 0, TYPER, 7);
        step();

        // execute backpressure for 3 cycles with fetch still offering
        bus.e_allow_in = 0;
        push(32'h400, 0, 32'h1234, 32'h33, 8);
        drive(32'h400, OP_REG, 10, 5, 3, 0, TYPER, 8);
        step();
        push(32'h404, 0, 32'hDEAD_BEEF, 0, 9);
        drive(32'h404, OP_REG, 11, 7, 0, 0, TYPER, 9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_allow_in", 32'(bus.d_allow_in), 0);
            chk("bp_hold_pc", bus.d_pc, 32'h400);
            step();
        end
        bus.e_allow_in = 1;
        @(negedge clk);
        step();
        bus.f_to_d_valid = 0;
        @(negedge clk);
        chk("bp_second_pc", bus.d_pc, 32'h404);
        repeat (3) step();

        chk("sb_drained", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
